prog_counter: RTL

//  Parametrised, runtime-programmable wrap counter for the VGA/timing path. Counts up or down

---
 rtl/prog_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prog_counter.sv
// Runtime-programmable up/down wrap counter with a shadowed limit, preload and a wrap pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module prog_counter #(
   parameter int COUNTER_WIDTH       = 8,
   parameter int COUNTER_MAX_DEFAULT = 192,
   parameter int CLEAR_ON_DISABLE    = 1,
   parameter int PRESCALE_WIDTH      = 4
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     ENABLE_IN,
   input  logic                     DIR_IN,
   input  logic                     LOAD_IN,
   input  logic [COUNTER_WIDTH-1:0] LOAD_VAL,
   input  logic                     MAX_WR,
   input  logic [COUNTER_WIDTH-1:0] MAX_IN,
`ifdef COUNTER_PRESCALE_EN
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE_IN,
`endif
   output logic [COUNTER_WIDTH-1:0] COUNT,
   output logic                     TRIG_OUT,
   output logic [COUNTER_WIDTH-1:0] MAX_OUT
);

   localparam logic [COUNTER_WIDTH-1:0] MAX_RST = COUNTER_WIDTH'(COUNTER_MAX_DEFAULT);

   if (PRESCALE_WIDTH < 1) begin : g_bad_prescale_width
      $error("prog_counter: PRESCALE_WIDTH must be at least 1");
   end
   if (COUNTER_MAX_DEFAULT < 0 || COUNTER_MAX_DEFAULT >= (2 ** COUNTER_WIDTH)) begin : g_bad_max_default
      $error("prog_counter: COUNTER_MAX_DEFAULT must fit in COUNTER_WIDTH bits");
   end

   logic [COUNTER_WIDTH-1:0] shadow;
   logic                     pending;
   logic                     pre_hit;
   logic                     step;
   logic                     wrap;
   logic                     apply;
   logic [COUNTER_WIDTH-1:0] count_nxt;
   logic                     trig_nxt;

`ifdef COUNTER_PRESCALE_EN
   logic [PRESCALE_WIDTH-1:0] pre;

   assign pre_hit = (pre == PRESCALE_IN);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pre <= '0;
      end else if (LOAD_IN || !ENABLE_IN || pre_hit) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end
`else
   assign pre_hit = 1'b1;
`endif

   always_comb begin
      step  = ENABLE_IN & ~LOAD_IN & pre_hit;
      wrap  = step & (DIR_IN ? (COUNT == '0) : (COUNT >= MAX_OUT));
      // The limit is swapped only where no count is in flight against it.
      apply = ~LOAD_IN & (wrap | ~ENABLE_IN);

      count_nxt = COUNT;
      trig_nxt  = 1'b0;
      if (LOAD_IN) begin
         count_nxt = (LOAD_VAL > MAX_OUT) ? MAX_OUT : LOAD_VAL;
      end else if (ENABLE_IN) begin
         if (step) begin
            if (!DIR_IN) begin
               if (COUNT >= MAX_OUT) begin
                  count_nxt = '0;
                  trig_nxt  = 1'b1;
               end else begin
                  count_nxt = COUNT + 1'b1;
               end
            end else begin
               if (COUNT == '0) begin
                  count_nxt = MAX_OUT;
                  trig_nxt  = 1'b1;
               end else if (COUNT > MAX_OUT) begin
                  count_nxt = MAX_OUT;
               end else begin
                  count_nxt = COUNT - 1'b1;
               end
            end
         end
      end else if (CLEAR_ON_DISABLE != 0) begin
         count_nxt = '0;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         COUNT    <= '0;
         TRIG_OUT <= 1'b0;
      end else begin
         COUNT    <= count_nxt;
         TRIG_OUT <= trig_nxt;
      end
   end

   // A write landing on an apply edge stays pending: the old shadow (if any) moves first.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         MAX_OUT <= MAX_RST;
         shadow  <= MAX_RST;
         pending <= 1'b0;
      end else begin
         if (apply && pending) begin
            MAX_OUT <= shadow;
         end
         if (MAX_WR) begin
            shadow  <= MAX_IN;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

endmodule
